// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer datapath.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  localparam int unsigned TICK_DIV_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    ModeClear,
    ModeSet,
    ModeCount,
    ModeHold
  } mode_e;

  function automatic mode_e decode_mode(input logic reset_timer, input logic enable_counter,
                                        input logic forward, input logic expired);
    if (reset_timer) begin
      return ModeClear;
    end else if (enable_counter && forward) begin
      return ModeSet;
    end else if (enable_counter && !forward && !expired) begin
      return ModeCount;
    end
    return ModeHold;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV cycles while run is high,
// counter held at zero whenever run is low.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == CntLast);

  always_comb begin
    cnt_d = cnt_q;
    if (!run || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_countdown_counter.sv
// MM:SS BCD countdown datapath for the VGA timer: clear, manual set, 1 Hz countdown, expiry flag.
// Optional expiry blink on display_blank when TIMER_EXPIRE_BLINK_EN is defined.
module timer_countdown_counter
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable_counter,
  input  logic       forward,
  input  logic       reset_timer,
  input  logic       increment_seg,
  input  logic       increment_min,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       expired,
  output logic       display_blank
);

  bcd_t  min_tens_q, min_tens_d, min_ones_q, min_ones_d;
  bcd_t  sec_tens_q, sec_tens_d, sec_ones_q, sec_ones_d;
  logic  expired_q, expired_d;
  logic  prev_seg_q, prev_min_q;
  logic  seg_edge, min_edge, time_zero, tick;
  mode_e mode;

  assign mode      = decode_mode(reset_timer, enable_counter, forward, expired_q);
  assign seg_edge  = increment_seg & ~prev_seg_q;
  assign min_edge  = increment_min & ~prev_min_q;
  assign time_zero = (min_tens_q == '0) && (min_ones_q == '0) &&
                     (sec_tens_q == '0) && (sec_ones_q == '0);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_count_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (mode == ModeCount),
    .tick (tick)
  );

  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    expired_d  = expired_q;
    unique case (mode)
      ModeClear: begin
        min_tens_d = '0;
        min_ones_d = '0;
        sec_tens_d = '0;
        sec_ones_d = '0;
        expired_d  = 1'b0;
      end
      ModeSet: begin
        // Seconds wrap 59->00 without touching the minutes.
        if (seg_edge) begin
          if (sec_ones_q == DIGIT_MAX) begin
            sec_ones_d = '0;
            sec_tens_d = (sec_tens_q == SEC_TENS_MAX) ? '0 : sec_tens_q + 4'd1;
          end else begin
            sec_ones_d = sec_ones_q + 4'd1;
          end
        end
        if (min_edge) begin
          if (min_ones_q == DIGIT_MAX) begin
            min_ones_d = '0;
            min_tens_d = (min_tens_q == DIGIT_MAX) ? '0 : min_tens_q + 4'd1;
          end else begin
            min_ones_d = min_ones_q + 4'd1;
          end
        end
        if (seg_edge || min_edge) begin
          expired_d = 1'b0;
        end
      end
      ModeCount: begin
        if (time_zero) begin
          expired_d = 1'b1;
        end else if (tick) begin
          if (sec_ones_q != '0) begin
            sec_ones_d = sec_ones_q - 4'd1;
          end else begin
            sec_ones_d = DIGIT_MAX;
            if (sec_tens_q != '0) begin
              sec_tens_d = sec_tens_q - 4'd1;
            end else begin
              sec_tens_d = SEC_TENS_MAX;
              if (min_ones_q != '0) begin
                min_ones_d = min_ones_q - 4'd1;
              end else begin
                min_ones_d = DIGIT_MAX;
                min_tens_d = min_tens_q - 4'd1;
              end
            end
          end
        end
      end
      ModeHold: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_tens_q <= '0;
      min_ones_q <= '0;
      sec_tens_q <= '0;
      sec_ones_q <= '0;
      expired_q  <= 1'b0;
      prev_seg_q <= 1'b0;
      prev_min_q <= 1'b0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      expired_q  <= expired_d;
      // Sampled in every mode so strobes held through a clear never look like fresh edges.
      prev_seg_q <= increment_seg;
      prev_min_q <= increment_min;
    end
  end

  assign min_tens = min_tens_q;
  assign min_ones = min_ones_q;
  assign sec_tens = sec_tens_q;
  assign sec_ones = sec_ones_q;
  assign expired  = expired_q;

`ifdef TIMER_EXPIRE_BLINK_EN
  logic blink_tick;
  logic blank_q, blank_d;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_blink_prescaler (
    .clk  (clk),
    .reset(reset),
    .run  (expired_q),
    .tick (blink_tick)
  );

  assign blank_d = expired_d ? (blank_q ^ blink_tick) : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      blank_q <= 1'b0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign display_blank = blank_q;
`else
  assign display_blank = 1'b0;
`endif

endmodule

// File: tb/tb_timer_countdown_counter.sv
// Self-checking bench for timer_countdown_counter: vector table, corner sequences,
// and random stimulus against a seconds-based reference model.
module tb_timer_countdown_counter;

  localparam int TDIV = 4;
`ifdef TIMER_EXPIRE_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, fwd, rt, seg, mn;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       expired, display_blank;

  int total = 0;
  int bad   = 0;

  // Reference model state: time as minutes/seconds integers.
  int m_min = 0, m_sec = 0, m_run = 0, m_age = 0;
  bit m_exp = 0, m_ps = 0, m_pm = 0, m_blank = 0;
  int mode_sel = 0;

  typedef struct packed {
    logic       rst, en, fwd, rt, seg, mn;
    logic [3:0] mt, mo, st, so;
    logic       ex;
  } vec_t;
  vec_t vecs[$];

  timer_countdown_counter #(
    .TICK_DIV(TDIV)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .enable_counter(en),
    .forward       (fwd),
    .reset_timer   (rt),
    .increment_seg (seg),
    .increment_min (mn),
    .min_tens      (min_tens),
    .min_ones      (min_ones),
    .sec_tens      (sec_tens),
    .sec_ones      (sec_ones),
    .expired       (expired),
    .display_blank (display_blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_time(input string name, input int mm, input int ss, input bit ex);
    check({name, "_time"}, int'(min_tens) * 1000 + int'(min_ones) * 100 +
          int'(sec_tens) * 10 + int'(sec_ones), (mm / 10) * 1000 + (mm % 10) * 100 +
          (ss / 10) * 10 + ss % 10);
    check({name, "_exp"}, int'(expired), int'(ex));
  endtask

  task automatic model_next();
    bit old_exp = m_exp;
    bit es = seg && !m_ps;
    bit em = mn && !m_pm;
    int secs = m_min * 60 + m_sec;
    if (rst) begin
      m_min = 0; m_sec = 0; m_exp = 0; m_run = 0;
    end else if (rt) begin
      m_min = 0; m_sec = 0; m_exp = 0; m_run = 0;
    end else if (en && fwd) begin
      if (es) m_sec = (m_sec + 1) % 60;
      if (em) m_min = (m_min + 1) % 100;
      if (es || em) m_exp = 0;
      m_run = 0;
    end else if (en && !m_exp) begin
      if (secs == 0) begin
        m_exp = 1;
      end else if (m_run % TDIV == TDIV - 1) begin
        secs--;
        m_min = secs / 60;
        m_sec = secs % 60;
      end
      m_run++;
    end else begin
      m_run = 0;
    end
    m_ps = rst ? 1'b0 : seg;
    m_pm = rst ? 1'b0 : mn;
    if (BlinkEn && m_exp && old_exp) begin
      m_age++;
      if (m_age % TDIV == 0) m_blank = !m_blank;
    end else begin
      m_age = 0;
      m_blank = 0;
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    check_time("model", m_min, m_sec, m_exp);
    check("model_blank", int'(display_blank), int'(m_blank));
  endtask

  task automatic drive(input logic r, e, f, t, s, m);
    rst = r; en = e; fwd = f; rt = t; seg = s; mn = m;
  endtask

  task automatic add(input logic r, e, f, t, s, m, input int mm, input int ss, input logic x);
    vecs.push_back({r, e, f, t, s, m, 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), x});
  endtask

  task automatic set_time(input int mm, input int ss);
    drive(0, 1, 1, 1, 0, 0); step();
    rt = 0; step();
    repeat (ss) begin seg = 1; step(); seg = 0; step(); end
    repeat (mm) begin mn = 1; step(); mn = 0; step(); end
  endtask

  initial begin
    drive(1, 0, 0, 0, 1, 1);

    // r e f t s m  mm ss ex
    add(1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 1, 1, 1, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 1, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 1, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 1, 0, 0, 2, 0);
    add(0, 1, 1, 0, 0, 0, 0, 2, 0);
    add(0, 1, 1, 0, 1, 0, 0, 3, 0);
    add(0, 1, 1, 0, 0, 1, 1, 3, 0);
    add(0, 1, 1, 0, 0, 0, 1, 3, 0);
    add(0, 1, 1, 0, 0, 1, 2, 3, 0);
    add(0, 1, 1, 0, 0, 0, 2, 3, 0);
    add(0, 1, 1, 0, 1, 1, 3, 4, 0);
    add(0, 0, 1, 0, 1, 0, 3, 4, 0);
    add(0, 1, 1, 0, 1, 0, 3, 4, 0);
    add(0, 1, 1, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].fwd, vecs[i].rt, vecs[i].seg, vecs[i].mn);
      step();
      check($sformatf("vec%0d", i) , int'({min_tens, min_ones, sec_tens, sec_ones}),
            int'({vecs[i].mt, vecs[i].mo, vecs[i].st, vecs[i].so}));
      check($sformatf("vec%0d_exp", i), int'(expired), int'(vecs[i].ex));
    end

    // Seconds wrap without carry, minutes wrap through 99.
    set_time(0, 58);
    repeat (61) begin seg = 1; step(); seg = 0; step(); end
    check_time("sec_wrap", 0, 59, 0);
    repeat (100) begin mn = 1; step(); mn = 0; step(); end
    check_time("min_wrap", 0, 59, 0);

    // Countdown latency from 01:00.
    set_time(1, 0);
    drive(0, 1, 0, 0, 0, 0);
    repeat (TDIV - 1) step();
    check_time("cnt_pre", 1, 0, 0);
    step();
    check_time("cnt_first", 0, 59, 0);
    repeat (40 - TDIV) step();
    check_time("cnt_40", 0, 50, 0);

    // Expiry from 00:01, freeze, blink, clear.
    set_time(0, 1);
    drive(0, 1, 0, 0, 0, 0);
    repeat (TDIV) step();
    check_time("exp_zero", 0, 0, 0);
    step();
    check_time("exp_set", 0, 0, 1);
    repeat (TDIV - 1) step();
    check("blank_early", int'(display_blank), 0);
    step();
    check("blank_on", int'(display_blank), BlinkEn ? 1 : 0);
    repeat (TDIV) step();
    check("blank_off", int'(display_blank), 0);
    check_time("exp_frozen", 0, 0, 1);
    rt = 1; step();
    check_time("exp_clear", 0, 0, 0);
    check("blank_clear", int'(display_blank), 0);

    // COUNT entered at 00:00.
    drive(0, 1, 0, 0, 0, 0); step();
    check_time("zero_entry", 0, 0, 1);

    // Hold mid-second discards the partial second.
    set_time(0, 5);
    drive(0, 1, 0, 0, 0, 0);
    repeat (2) step();
    en = 0; step();
    en = 1;
    repeat (TDIV - 1) step();
    check_time("hold_pre", 0, 5, 0);
    step();
    check_time("hold_resume", 0, 4, 0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mode_sel = int'($urandom_range(0, 3));
      rst = ($urandom_range(0, 299) == 0);
      rt  = ($urandom_range(0, 99) < 2);
      unique case (mode_sel)
        0:       begin en = 1; fwd = 1; end
        1, 2:    begin en = 1; fwd = 0; end
        default: begin en = 0; fwd = 1'($urandom_range(0, 1)); end
      endcase
      seg = ($urandom_range(0, 3) == 0);
      mn  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
